// File: rtl/stream_watchdog_pkg.sv
// Shared types and helpers for the stream watchdog controller.
package stream_watchdog_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    TRIPPED  = 2'd2
  } wd_state_e;

  function automatic int unsigned idx_width(input int unsigned num_streams);
    return (num_streams > 1) ? $clog2(num_streams) : 1;
  endfunction

endpackage

// File: rtl/stream_watchdog_chan.sv
// One monitored channel: enable/arm/trip FSM with a saturating inactivity counter.
module stream_watchdog_chan
  import stream_watchdog_pkg::*;
#(
  parameter int unsigned CntWidth  = 16,
  parameter bit          StallOnly = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] timeout_i,
  input  logic                clear_i,
  input  logic                valid_i,
  input  logic                ready_i,
  output logic                trip_o,
  output logic                pending_set_o
);

  wd_state_e           state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth:0]   cnt_inc;
  logic                handshake, count_cycle, hit;

  assign handshake   = valid_i & ready_i;
  assign count_cycle = StallOnly ? (valid_i & ~ready_i) : ~handshake;
  // One extra bit so cnt+1 never wraps before the compare or saturation test.
  assign cnt_inc     = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
  assign hit         = (timeout_i != '0) && (cnt_inc >= {1'b0, timeout_i});

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_set_o = 1'b0;
    unique case (state_q)
      DISABLED: begin
        cnt_d = '0;
        if (en_i) state_d = ARMED;
      end
      ARMED: begin
        if (!en_i) begin
          state_d = DISABLED;
          cnt_d   = '0;
        end else if (clear_i || handshake) begin
          cnt_d = '0;
        end else if (count_cycle) begin
          if (hit) begin
            state_d       = TRIPPED;
            pending_set_o = 1'b1;
          end else if (!cnt_inc[CntWidth]) begin
            cnt_d = cnt_inc[CntWidth-1:0];
          end
        end
      end
      TRIPPED: begin
        if (clear_i) begin
          state_d = en_i ? ARMED : DISABLED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = DISABLED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DISABLED;
      cnt_q   <= '0;
      trip_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trip_o  <= (state_d == TRIPPED);
    end
  end

endmodule

// File: rtl/stream_watchdog_ctrl.sv
// Watchdog over NumStreams ready/valid channels with a round-robin trip report stream.
module stream_watchdog_ctrl
  import stream_watchdog_pkg::*;
#(
  parameter int unsigned NumStreams = 4,
  parameter int unsigned CntWidth   = 16,
  parameter bit          StallOnly  = 1'b0,
  parameter int unsigned IdxWidth   = idx_width(NumStreams)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumStreams-1:0] en_i,
  input  logic [CntWidth-1:0]   timeout_i,
  input  logic [NumStreams-1:0] clear_i,
  input  logic [NumStreams-1:0] valid_i,
  input  logic [NumStreams-1:0] ready_i,
  output logic [NumStreams-1:0] trip_o,
  output logic                  any_trip_o,
  output logic                  rpt_valid_o,
  input  logic                  rpt_ready_i,
  output logic [IdxWidth-1:0]   rpt_idx_o
);

  logic [NumStreams-1:0] pending_set;
  logic [NumStreams-1:0] pending_q, pending_d;
  logic                  rpt_valid_d;
  logic [IdxWidth-1:0]   rpt_idx_d, rr_q, rr_d;
  logic [IdxWidth-1:0]   gnt_idx, cand_idx;
  logic                  gnt_found;
  int unsigned           cand;

  for (genvar g = 0; g < NumStreams; g++) begin : g_chan
    stream_watchdog_chan #(
      .CntWidth  (CntWidth),
      .StallOnly (StallOnly)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (en_i[g]),
      .timeout_i     (timeout_i),
      .clear_i       (clear_i[g]),
      .valid_i       (valid_i[g]),
      .ready_i       (ready_i[g]),
      .trip_o        (trip_o[g]),
      .pending_set_o (pending_set[g])
    );
  end

  assign any_trip_o = |trip_o;

  // First pending channel at or after the rr pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NumStreams; k++) begin
      cand     = (int'(rr_q) + k) % NumStreams;
      cand_idx = cand[IdxWidth-1:0];
      if (!gnt_found && pending_q[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    pending_d   = pending_q;
    rpt_valid_d = rpt_valid_o;
    rpt_idx_d   = rpt_idx_o;
    rr_d        = rr_q;
    if (rpt_valid_o) begin
      if (rpt_ready_i) begin
        pending_d[rpt_idx_o] = 1'b0;
        rpt_valid_d          = 1'b0;
        rr_d = (rpt_idx_o == IdxWidth'(NumStreams - 1)) ? '0 : rpt_idx_o + 1'b1;
      end
    end else if (gnt_found) begin
      rpt_valid_d = 1'b1;
      rpt_idx_d   = gnt_idx;
    end
    // New trips land after the clear so a re-trip on the acked channel is kept.
    pending_d = pending_d | pending_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      rpt_valid_o <= 1'b0;
      rpt_idx_o   <= '0;
      rr_q        <= '0;
    end else begin
      pending_q   <= pending_d;
      rpt_valid_o <= rpt_valid_d;
      rpt_idx_o   <= rpt_idx_d;
      rr_q        <= rr_d;
    end
  end

endmodule

// File: tb/tb_stream_watchdog_ctrl.sv
// Directed bench: expected report indices go into a queue, a monitor checks the report stream.
module tb_stream_watchdog_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en = '0, clear = '0, valid = '0, ready = '0;
  logic [15:0] timeout = 16'd8;
  logic        rpt_ready = 1'b1;

  logic [3:0]  trip, trip2;
  logic        any_trip, any_trip2, rpt_valid, rpt_valid2;
  logic [1:0]  rpt_idx, rpt_idx2;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [1:0]  exp_q[$];

  always #5 clk = ~clk;

  stream_watchdog_ctrl #(.NumStreams(4), .CntWidth(16), .StallOnly(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .timeout_i(timeout), .clear_i(clear),
    .valid_i(valid), .ready_i(ready), .trip_o(trip), .any_trip_o(any_trip),
    .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready), .rpt_idx_o(rpt_idx)
  );

  stream_watchdog_ctrl #(.NumStreams(4), .CntWidth(16), .StallOnly(1'b1)) u_dut_stall (
    .clk_i(clk), .rst_i(rst), .en_i(en), .timeout_i(timeout), .clear_i(clear),
    .valid_i(valid), .ready_i(ready), .trip_o(trip2), .any_trip_o(any_trip2),
    .rpt_valid_o(rpt_valid2), .rpt_ready_i(1'b1), .rpt_idx_o(rpt_idx2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0; clear = '0; valid = '0; ready = '0;
    timeout = 16'd8; rpt_ready = 1'b1;
    exp_q.delete();
    step(1);
    rst = 1'b0;
  endtask

  // Monitor: scoreboard pop on each report handshake plus hold/gap protocol checks.
  initial begin
    logic       prev_hold, prev_hs;
    logic [1:0] prev_idx, exp_idx;
    prev_hold = 1'b0; prev_hs = 1'b0; prev_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0; prev_hs = 1'b0;
      end else begin
        if (prev_hs) chk("rpt_gap_after_ack", 32'(rpt_valid), 32'd0);
        if (prev_hold) begin
          chk("rpt_valid_hold", 32'(rpt_valid), 32'd1);
          chk("rpt_idx_hold", 32'(rpt_idx), 32'(prev_idx));
        end
        if (rpt_valid && rpt_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_report", 32'(rpt_idx), 32'hffff_ffff);
          end else begin
            exp_idx = exp_q.pop_front();
            chk("report_idx", 32'(rpt_idx), 32'(exp_idx));
          end
        end
        prev_hold = rpt_valid && !rpt_ready;
        prev_hs   = rpt_valid && rpt_ready;
        prev_idx  = rpt_idx;
      end
    end
  end

  initial begin
    // Reset values and basic trip timing on channel 0.
    do_reset();
    chk("reset_trip", 32'(trip), 32'd0);
    chk("reset_rpt_valid", 32'(rpt_valid), 32'd0);
    chk("reset_rpt_idx", 32'(rpt_idx), 32'd0);
    en = 4'b0001; valid = 4'b0001; ready = '0;
    exp_q.push_back(2'd0);
    step(8);
    chk("t1_no_trip_edge7", 32'(trip), 32'd0);
    step(1);
    chk("t1_trip_edge8", 32'(trip), 32'b0001);
    chk("t1_no_rpt_edge8", 32'(rpt_valid), 32'd0);
    step(1);
    chk("t1_rpt_valid_edge9", 32'(rpt_valid), 32'd1);
    chk("t1_rpt_idx_edge9", 32'(rpt_idx), 32'd0);
    step(1);
    chk("t1_rpt_drop_edge10", 32'(rpt_valid), 32'd0);

    // Channel 1: handshake every 7th cycle never trips; an 8-cycle gap does.
    do_reset();
    en = 4'b0010; valid = 4'b0010;
    for (int i = 0; i < 100; i++) begin
      ready = (i > 0 && i % 7 == 0) ? 4'b0010 : 4'b0000;
      step(1);
    end
    chk("t2_periodic_hs_no_trip", 32'(trip), 32'd0);
    ready = 4'b0010;
    step(1);
    ready = '0;
    exp_q.push_back(2'd1);
    step(7);
    chk("t2_gap7_no_trip", 32'(trip), 32'd0);
    step(1);
    chk("t2_gap8_trip", 32'(trip), 32'b0010);
    chk("t2_any_trip", 32'(any_trip), 32'd1);
    step(4);

    // StallOnly: idle valid=0 never counts there, but counts in the default mode.
    do_reset();
    en = 4'b0011; valid = 4'b0010; ready = '0;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    step(50);
    chk("t3_count_all_trips", 32'(trip), 32'b0011);
    chk("t3_stall_only_trips", 32'(trip2), 32'b0010);

    // Simultaneous trips on 0,2,3 from rr=0, then again with rr moved to 3.
    do_reset();
    en = 4'b1101; valid = 4'b1101;
    exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    step(30);
    chk("t4_all_reported", 32'(exp_q.size()), 32'd0);
    clear = 4'b1101; en = '0; valid = '0;
    step(1);
    clear = '0;
    en = 4'b0100; valid = 4'b0100;
    exp_q.push_back(2'd2);
    step(20);
    clear = 4'b0100; en = '0; valid = '0;
    step(1);
    clear = '0;
    en = 4'b1101; valid = 4'b1101;
    exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    step(30);
    chk("t4_rr3_reported", 32'(exp_q.size()), 32'd0);

    // Backpressure: report for 0 held while channel 2 trips, then both delivered.
    do_reset();
    rpt_ready = 1'b0;
    en = 4'b0001; valid = 4'b0001;
    step(4);
    en = 4'b0101; valid = 4'b0101;
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    step(20);
    chk("t5_held_valid", 32'(rpt_valid), 32'd1);
    chk("t5_held_idx", 32'(rpt_idx), 32'd0);
    chk("t5_both_tripped", 32'(trip), 32'b0101);
    rpt_ready = 1'b1;
    step(8);
    chk("t5_both_reported", 32'(exp_q.size()), 32'd0);

    // Clear beats a trip in the same cycle; clear with en=0 keeps the report.
    do_reset();
    rpt_ready = 1'b0;
    en = 4'b0001; valid = 4'b0001;
    step(8);
    clear = 4'b0001;
    step(1);
    clear = '0;
    chk("t6_clear_beats_trip", 32'(trip), 32'd0);
    step(7);
    chk("t6_recount_edge15", 32'(trip), 32'd0);
    step(1);
    chk("t6_recount_trip_edge16", 32'(trip), 32'b0001);
    exp_q.push_back(2'd0);
    en = '0; clear = 4'b0001;
    step(1);
    clear = '0;
    chk("t6_cleared_disabled", 32'(trip), 32'd0);
    chk("t6_any_trip_low", 32'(any_trip), 32'd0);
    step(3);
    chk("t6_report_survives_clear", 32'(rpt_valid), 32'd1);
    rpt_ready = 1'b1;
    step(25);
    chk("t6_stays_disabled", 32'(trip), 32'd0);
    chk("t6_report_once", 32'(exp_q.size()), 32'd0);

    // Dropping en while armed abandons the count.
    do_reset();
    en = 4'b0001; valid = 4'b0001;
    step(5);
    en = '0;
    step(20);
    chk("t7_en_drop_no_trip", 32'(trip), 32'd0);

    // Asynchronous reset mid-report.
    do_reset();
    rpt_ready = 1'b0;
    en = 4'b0001; valid = 4'b0001;
    exp_q.push_back(2'd0);
    step(12);
    chk("t8_report_in_flight", 32'(rpt_valid), 32'd1);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t8_async_trip", 32'(trip), 32'd0);
    chk("t8_async_rpt_valid", 32'(rpt_valid), 32'd0);
    chk("t8_async_rpt_idx", 32'(rpt_idx), 32'd0);
    step(1);
    rst = 1'b0;
    rpt_ready = 1'b1;

    // timeout 0 never trips; lowering it below cnt trips on the next counting edge.
    en = 4'b1111; valid = 4'b1111; ready = '0; timeout = 16'd0;
    step(300);
    chk("t9_timeout0_no_trip", 32'(trip), 32'd0);
    timeout = 16'd5;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    step(1);
    chk("t9_live_timeout_trip", 32'(trip), 32'b1111);
    step(20);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
